// File: rtl/stream_demultiplexor.sv
// stream_demultiplexor: 1:2 valid/ready demux with an independent FIFO per output.
// Optional DEMUX_STATS_EN adds saturating per-output push counters stat0/stat1.
module stream_demultiplexor #(
    parameter int WIDTH = 5,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out0_data,
    output logic             out0_valid,
    input  logic             out0_ready,
    output logic [WIDTH-1:0] out1_data,
    output logic             out1_valid,
    input  logic             out1_ready
`ifdef DEMUX_STATS_EN
    ,
    output logic [7:0]       stat0,
    output logic [7:0]       stat1
`endif
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem   [2][DEPTH];
    logic [AW-1:0]    wptr  [2];
    logic [AW-1:0]    rptr  [2];
    logic [AW:0]      count [2];

    logic [1:0] full;
    logic [1:0] push;
    logic [1:0] pop;
    logic       accept;

    // Ready looks only at the selected FIFO's registered fill level,
    // so a same-cycle pop never opens a path from outN_ready.
    assign full[0]  = (count[0] == FULL_CNT);
    assign full[1]  = (count[1] == FULL_CNT);
    assign in_ready = !full[in_sel];
    assign accept   = in_valid && in_ready;
    assign push[0]  = accept && !in_sel;
    assign push[1]  = accept && in_sel;

    assign out0_valid = (count[0] != '0);
    assign out1_valid = (count[1] != '0);
    assign out0_data  = mem[0][rptr[0]];
    assign out1_data  = mem[1][rptr[1]];
    assign pop[0]     = out0_valid && out0_ready;
    assign pop[1]     = out1_valid && out1_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int n = 0; n < 2; n++) begin
                wptr[n]  <= '0;
                rptr[n]  <= '0;
                count[n] <= '0;
                for (int i = 0; i < DEPTH; i++) begin
                    mem[n][i] <= '0;
                end
            end
        end else begin
            for (int n = 0; n < 2; n++) begin
                if (push[n]) begin
                    mem[n][wptr[n]] <= in_data;
                    wptr[n]         <= wptr[n] + 1'b1;
                end
                if (pop[n]) begin
                    rptr[n] <= rptr[n] + 1'b1;
                end
                unique case ({push[n], pop[n]})
                    2'b10:   count[n] <= count[n] + 1'b1;
                    2'b01:   count[n] <= count[n] - 1'b1;
                    default: count[n] <= count[n];
                endcase
            end
        end
    end

`ifdef DEMUX_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat0 <= '0;
            stat1 <= '0;
        end else begin
            if (push[0] && (stat0 != 8'hFF)) begin
                stat0 <= stat0 + 8'd1;
            end
            if (push[1] && (stat1 != 8'hFF)) begin
                stat1 <= stat1 + 8'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_stream_demultiplexor.sv
// Bench for stream_demultiplexor: queue model checked every cycle plus
// directed scenarios with literal expectations.
module tb_stream_demultiplexor;

    localparam int W = 5;
    localparam int D = 2;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [W-1:0] in_data = '0;
    logic         in_sel = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] out0_data;
    logic         out0_valid;
    logic         out0_ready = 1'b0;
    logic [W-1:0] out1_data;
    logic         out1_valid;
    logic         out1_ready = 1'b0;
`ifdef DEMUX_STATS_EN
    logic [7:0]   stat0;
    logic [7:0]   stat1;
`endif

    stream_demultiplexor #(.WIDTH(W), .DEPTH(D)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_sel     (in_sel),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out0_data  (out0_data),
        .out0_valid (out0_valid),
        .out0_ready (out0_ready),
        .out1_data  (out1_data),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready)
`ifdef DEMUX_STATS_EN
        ,
        .stat0      (stat0),
        .stat1      (stat1)
`endif
    );

    always #5 clk = ~clk;

    typedef logic [W-1:0] wq_t[$];

    int  checks = 0;
    int  failures = 0;
    wq_t q0, q1, got0, got1, ex;
    bit  model_ok = 1'b0;
    int  s0 = 0;
    int  s1 = 0;
    bit  acc, p0, p1;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endfunction

    // Model: each output is a bounded queue; ready depends on fill before the edge.
    initial forever begin
        @(posedge clk);
        if (rst) begin
            q0.delete();
            q1.delete();
            s0 = 0;
            s1 = 0;
            model_ok = 1'b1;
        end else if (model_ok) begin
            if (out0_valid && out0_ready) got0.push_back(out0_data);
            if (out1_valid && out1_ready) got1.push_back(out1_data);
            acc = in_valid && ((in_sel ? q1.size() : q0.size()) < D);
            p0  = (q0.size() != 0) && out0_ready;
            p1  = (q1.size() != 0) && out1_ready;
            if (p0) void'(q0.pop_front());
            if (p1) void'(q1.pop_front());
            if (acc && in_sel) begin
                q1.push_back(in_data);
                if (s1 < 255) s1++;
            end
            if (acc && !in_sel) begin
                q0.push_back(in_data);
                if (s0 < 255) s0++;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (model_ok) begin
            chk("m_valid0", out0_valid, q0.size() != 0);
            chk("m_valid1", out1_valid, q1.size() != 0);
            if (q0.size() != 0) chk("m_data0", out0_data, q0[0]);
            if (q1.size() != 0) chk("m_data1", out1_data, q1[0]);
            chk("m_ready", in_ready, (in_sel ? q1.size() : q0.size()) != D);
`ifdef DEMUX_STATS_EN
            chk("m_stat0", stat0, s0);
            chk("m_stat1", stat1, s1);
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic s, input logic [W-1:0] d);
        in_valid = 1'b1;
        in_sel   = s;
        in_data  = d;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic chk_log(input string nm, input bit port);
        wq_t g;
        if (port) g = got1;
        else g = got0;
        chk({nm, "_count"}, g.size(), ex.size());
        for (int i = 0; i < ex.size(); i++) begin
            if (i < g.size()) chk(nm, g[i], ex[i]);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: no finish after 200000 time units");
        $fatal(1);
    end

    initial begin
        // reset held two cycles with a word offered
        rst = 1'b1;
        in_valid = 1'b1;
        in_data = 5'h1F;
        tick();
        tick();
        chk("rst_valid0", out0_valid, 0);
        chk("rst_valid1", out1_valid, 0);
        chk("rst_data0", out0_data, 0);
        chk("rst_data1", out1_data, 0);
        chk("rst_ready", in_ready, 1);
        rst = 1'b0;
        in_valid = 1'b0;
        tick();
        chk("rst_nopush0", out0_valid, 0);
        chk("rst_nopush1", out1_valid, 0);

        // routing with both consumers ready
        got0.delete();
        got1.delete();
        out0_ready = 1'b1;
        out1_ready = 1'b1;
        push(1'b0, 5'h03);
        chk("route_v0", out0_valid, 1);
        chk("route_d0", out0_data, 5'h03);
        push(1'b1, 5'h1C);
        chk("route_v0_gone", out0_valid, 0);
        chk("route_d1", out1_data, 5'h1C);
        push(1'b0, 5'h11);
        chk("route_d0b", out0_data, 5'h11);
        chk("route_v1_gone", out1_valid, 0);
        tick();
        ex = {5'h03, 5'h11};
        chk_log("route_log0", 1'b0);
        ex = {5'h1C};
        chk_log("route_log1", 1'b1);

        // full, blocking, no pass-through, wrap
        got0.delete();
        got1.delete();
        out0_ready = 1'b0;
        out1_ready = 1'b0;
        push(1'b0, 5'h01);
        push(1'b0, 5'h02);
        in_valid = 1'b1;
        in_sel = 1'b0;
        in_data = 5'h05;
        #1;
        chk("full_ready0", in_ready, 0);
        tick();
        chk("full_hold", out0_data, 5'h01);
        in_sel = 1'b1;
        in_data = 5'h0A;
        #1;
        chk("full_ready1", in_ready, 1);
        tick();
        in_valid = 1'b0;
        chk("full_d1", out1_data, 5'h0A);
        in_valid = 1'b1;
        in_sel = 1'b0;
        in_data = 5'h05;
        out0_ready = 1'b1;
        #1;
        chk("nopass_ready", in_ready, 0);
        tick();
        in_valid = 1'b0;
        chk("nopass_d0", out0_data, 5'h02);
        tick();
        chk("drain_v0", out0_valid, 0);
        out0_ready = 1'b0;
        push(1'b0, 5'h03);
        push(1'b0, 5'h04);
        chk("wrap_d0", out0_data, 5'h03);
        out0_ready = 1'b1;
        tick();
        chk("wrap_d0b", out0_data, 5'h04);
        tick();
        out1_ready = 1'b1;
        tick();
        ex = {5'h01, 5'h02, 5'h03, 5'h04};
        chk_log("wrap_log0", 1'b0);
        ex = {5'h0A};
        chk_log("wrap_log1", 1'b1);

        // simultaneous push and pop on FIFO 1
        got0.delete();
        got1.delete();
        out0_ready = 1'b0;
        out1_ready = 1'b0;
        push(1'b1, 5'h0B);
        chk("pp_d1", out1_data, 5'h0B);
        out1_ready = 1'b1;
        push(1'b1, 5'h15);
        out1_ready = 1'b0;
        chk("pp_v1", out1_valid, 1);
        chk("pp_d1b", out1_data, 5'h15);
        ex = {5'h0B};
        chk_log("pp_log_a", 1'b1);
        out1_ready = 1'b1;
        tick();
        out1_ready = 1'b0;
        chk("pp_empty", out1_valid, 0);
        ex = {5'h0B, 5'h15};
        chk_log("pp_log_b", 1'b1);

        // reset with both FIFOs full and consumers ready
        got0.delete();
        got1.delete();
        push(1'b0, 5'h01);
        push(1'b0, 5'h02);
        push(1'b1, 5'h03);
        push(1'b1, 5'h04);
        in_sel = 1'b0;
        #1;
        chk("mid_full0", in_ready, 0);
        in_sel = 1'b1;
        #1;
        chk("mid_full1", in_ready, 0);
        rst = 1'b1;
        out0_ready = 1'b1;
        out1_ready = 1'b1;
        tick();
        rst = 1'b0;
        out0_ready = 1'b0;
        out1_ready = 1'b0;
        chk("mid_v0", out0_valid, 0);
        chk("mid_v1", out1_valid, 0);
        chk("mid_nopop", got0.size() + got1.size(), 0);
        push(1'b1, 5'h07);
        chk("mid_d1", out1_data, 5'h07);
        out1_ready = 1'b1;
        tick();
        out1_ready = 1'b0;

`ifdef DEMUX_STATS_EN
        rst = 1'b1;
        tick();
        rst = 1'b0;
        out0_ready = 1'b1;
        out1_ready = 1'b1;
        in_valid = 1'b1;
        in_sel = 1'b0;
        for (int i = 0; i < 300; i++) begin
            in_data = W'(i);
            tick();
        end
        in_sel = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = W'(i + 7);
            tick();
        end
        in_valid = 1'b0;
        tick();
        chk("stat0_sat", stat0, 255);
        chk("stat1_cnt", stat1, 3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("stat0_rst", stat0, 0);
        chk("stat1_rst", stat1, 0);
`endif

        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/stream_demultiplexor.md
Name: stream_demultiplexor

Overview:
- Sequential 1:2 demultiplexer for a valid/ready stream of WIDTH-bit words.
- Each input word goes to output 0 or output 1 according to sel, sampled at the input handshake.
- Each output has its own DEPTH-entry FIFO. Backpressure on one output does not block traffic to the other.
- Sits downstream of producers that use the team's 2:1 multiplexer bus width. It splits one bus back into two consumers.

Parameters:
- WIDTH, 5, data bus width in bits.
- DEPTH, 2, entries per output FIFO. Power of two, minimum 2.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_data  input  WIDTH  input word.
- in_sel  input  1  destination: 0 selects output 0, 1 selects output 1.
- in_valid  input  1  producer has a word.
- in_ready  output  1  demux accepts the word this cycle.
- out0_data  output  WIDTH  head word of FIFO 0.
- out0_valid  output  1  FIFO 0 not empty.
- out0_ready  input  1  consumer 0 takes the head word.
- out1_data  output  WIDTH  head word of FIFO 1.
- out1_valid  output  1  FIFO 1 not empty.
- out1_ready  input  1  consumer 1 takes the head word.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset state:
  - While rst=1 at a rising edge, both FIFOs are cleared: pointers=0, counts=0, storage=0.
  - After that edge: out0_valid=0, out1_valid=0, out0_data=0, out1_data=0, in_ready=1.
  - Reset mid-operation discards all buffered words, with no output handshake for them.
  - rst has priority over any simultaneous push or pop.
- Input handshake:
  - in_ready = !full[in_sel], combinational from in_sel and the registered FIFO state.
  - in_ready does not depend on in_valid or on either outN_ready, so there is no combinational path from outN_ready to in_ready.
  - Push into FIFO[in_sel] when in_valid && in_ready at a rising edge.
  - in_sel and in_data matter only in a handshake cycle. in_sel may change while in_valid=1 and in_ready=0, and in_ready then follows the new in_sel.
- Output handshake:
  - outN_valid = (countN != 0). outN_data = storage at the head of FIFO N.
  - Pop FIFO N when outN_valid && outN_ready.
  - outN_ready while outN_valid=0 has no effect.
- Latency: a word accepted at edge k is presented on outN at the output from edge k onward. It can be consumed at edge k+1 at the earliest. There is no combinational input-to-output path.
- Ordering:
  - Each output preserves the input order of the words routed to it.
  - There is no ordering relation between output 0 and output 1.
- FIFO mechanics:
  - Write and read pointers are log2(DEPTH) bits and wrap from DEPTH-1 to 0.
  - Count is log2(DEPTH)+1 bits. full = (count==DEPTH); empty = (count==0).
- Simultaneous events:
  - Push and pop on the same FIFO in one cycle: count unchanged, both pointers advance. This is possible only when the FIFO is not full, because a full FIFO has in_ready=0.
  - No pass-through on full: a pop in the same cycle does not raise in_ready.
  - Push to one FIFO and pop from the other in the same cycle are independent.
  - Both outputs may pop in the same cycle.
- Throughput: one word per cycle sustained to either output, provided that output's consumer holds ready=1.

Optional Feature:
- Macro: DEMUX_STATS_EN.
- Defined:
  - Adds output ports stat0 and stat1, each 8 bits wide.
  - statN counts accepted input words routed to output N.
  - Each counter increments by 1 per push, saturates at 255, and resets to 0 on rst.
  - The counters are registered and updated on the same edge as the push.
- Undefined: the ports and counters do not exist. All other behaviour is identical.

Test Plan:
- Reset: hold rst=1 for 2 cycles with in_valid=1 -> both outN_valid=0, both outN_data=0, in_ready=1, no pushes occur.
- Routing: push 5'h03 (sel=0), 5'h1C (sel=1), 5'h11 (sel=0) with both readies=1 ->
  - out0 delivers 5'h03 then 5'h11.
  - out1 delivers 5'h1C.
  - Each word is valid starting the cycle after its acceptance.
- Full, wrap and blocking:
  - out0_ready=0; push 5'h01 and 5'h02 to sel=0 -> in_ready=0 while in_sel=0.
  - Switch in_sel=1 -> in_ready=1, and 5'h0A goes to out1.
  - Release out0_ready -> 5'h01 then 5'h02, with the pointer wrap correct on a refill with 5'h03 and 5'h04.
- Simultaneous push and pop: FIFO 1 holds one word and out1_ready=1 while pushing 5'h15 to sel=1 -> count stays 1, next head is 5'h15, no loss or duplication.
- Reset mid-operation: both FIFOs full, assert rst one cycle -> both valids 0 next cycle; pushing 5'h07 to sel=1 afterwards yields out1_data=5'h07.
- DEMUX_STATS_EN defined:
  - Push 300 words to sel=0 and 3 words to sel=1 -> stat0=255 (saturated), stat1=3.
  - Assert rst -> both counters 0.
